// File: rtl/mp_add_seq.sv
// Word-serial multi-precision adder: streams WORDS x 64-bit operand words LSW first
// through one shared add-one carry-select adder and chains the carry between beats.

module a1csah64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] s,
  output logic        gen,
  output logic        prop
);
  logic [64:0] sum0_s;
  logic [63:0] sum1_s;

  // Both candidate sums are formed up front; cin only picks one of them.
  always_comb begin
    sum0_s = {1'b0, a} + {1'b0, b};
    sum1_s = sum0_s[63:0] + 64'd1;
    gen    = sum0_s[64];
    prop   = &(a ^ b);
    if (cin) begin
      s = sum1_s;
    end else begin
      s = sum0_s[63:0];
    end
  end
endmodule

module mp_add_seq #(
  parameter int WORDS = 4,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_a,
  input  logic [63:0]   in_b,
  input  logic          in_cin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_s,
  output logic [CW-1:0] out_idx,
  output logic          out_last,
  output logic          out_cout,
  output logic          busy
);
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

  logic [CW-1:0] idx_r;
  logic          cy_r;
  logic          adder_cin_s;
  logic [63:0]   sum_s;
  logic          gen_s;
  logic          prop_s;
  logic          c_next_s;
  logic          last_s;
  logic          accept_s;

  // Carry source selection, handshake and beat bookkeeping.
  always_comb begin
    if (idx_r == {CW{1'b0}}) begin
      adder_cin_s = in_cin;
    end else begin
      adder_cin_s = cy_r;
    end
    c_next_s = gen_s | (prop_s & adder_cin_s);
    last_s   = (idx_r == LAST_IDX);
    in_ready = ~abort & (~out_valid | out_ready);
    accept_s = in_valid & in_ready;
    busy     = (idx_r != {CW{1'b0}});
  end

  a1csah64 u_add (
    .a    (in_a),
    .b    (in_b),
    .cin  (adder_cin_s),
    .s    (sum_s),
    .gen  (gen_s),
    .prop (prop_s)
  );

  // Beat counter, inter-beat carry and the one-entry output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_r     <= {CW{1'b0}};
      cy_r      <= 1'b0;
      out_valid <= 1'b0;
      out_s     <= 64'd0;
      out_idx   <= {CW{1'b0}};
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
    end else if (accept_s) begin
      out_valid <= 1'b1;
      out_s     <= sum_s;
      out_idx   <= idx_r;
      out_last  <= last_s;
      out_cout  <= last_s ? c_next_s : 1'b0;
      // Wrapping clears the carry so nothing leaks into the next transaction.
      if (last_s) begin
        idx_r <= {CW{1'b0}};
        cy_r  <= 1'b0;
      end else begin
        idx_r <= idx_r + {{(CW-1){1'b0}}, 1'b1};
        cy_r  <= c_next_s;
      end
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (abort) begin
        idx_r <= {CW{1'b0}};
        cy_r  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq: directed scenarios plus random transactions
// compared against a full-width 257-bit sum.

module tb_mp_add_seq;
  localparam int WORDS = 4;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst_n, abort, in_valid, in_cin, out_ready;
  logic [63:0]   in_a, in_b;
  logic          in_ready, out_valid, out_last, out_cout, busy;
  logic [63:0]   out_s;
  logic [CW-1:0] out_idx;

  int errors = 0;
  int checks = 0;

  mp_add_seq #(.WORDS(WORDS), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .out_idx(out_idx),
    .out_last(out_last), .out_cout(out_cout), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive beat i of transaction (a,b,cin) and check the registered result one edge later.
  task automatic beat(input int i, input logic [255:0] a, input logic [255:0] b, input logic cin);
    logic [256:0] r;
    r = {1'b0, a} + {1'b0, b} + {256'd0, cin};
    in_valid = 1'b1;
    in_a     = a[64*i +: 64];
    in_b     = b[64*i +: 64];
    in_cin   = (i == 0) ? cin : 1'($urandom);
    #1;
    chk($sformatf("in_ready b%0d", i), {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    chk($sformatf("out_valid b%0d", i), {63'd0, out_valid}, 64'd1);
    chk($sformatf("out_s b%0d", i), out_s, r[64*i +: 64]);
    chk($sformatf("out_idx b%0d", i), {60'd0, out_idx}, 64'(i));
    chk($sformatf("out_last b%0d", i), {63'd0, out_last}, (i == WORDS-1) ? 64'd1 : 64'd0);
    chk($sformatf("out_cout b%0d", i), {63'd0, out_cout}, (i == WORDS-1) ? {63'd0, r[256]} : 64'd0);
    chk($sformatf("busy b%0d", i), {63'd0, busy}, (i == WORDS-1) ? 64'd0 : 64'd1);
  endtask

  task automatic txn(input logic [255:0] a, input logic [255:0] b, input logic cin);
    for (int i = 0; i < WORDS; i++) beat(i, a, b, cin);
  endtask

  initial begin
    logic [255:0] ones, b1, ra, rb;
    ones = {256{1'b1}};
    b1   = 256'd1;

    // Reset with in_valid asserted: nothing may be accepted.
    rst_n = 1'b0; abort = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_a = 64'h1234; in_b = 64'h5678; in_cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst out_s", out_s, 64'd0);
    chk("rst out_idx", {60'd0, out_idx}, 64'd0);
    chk("rst out_last", {63'd0, out_last}, 64'd0);
    chk("rst out_cout", {63'd0, out_cout}, 64'd0);
    chk("rst busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Full ripple across all words.
    txn(ones, b1, 1'b0);

    // Carry-in only, then zeros to show the carry was cleared on wrap.
    txn(256'd0, 256'd0, 1'b1);
    txn(256'd0, 256'd0, 1'b0);

    // Backpressure after beat 1.
    beat(0, ones, b1, 1'b0);
    beat(1, ones, b1, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = ones[128 +: 64]; in_b = 64'd0;
    #1;
    chk("bp in_ready", {63'd0, in_ready}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp out_valid c%0d", k), {63'd0, out_valid}, 64'd1);
      chk($sformatf("bp out_s c%0d", k), out_s, 64'd0);
      chk($sformatf("bp out_idx c%0d", k), {60'd0, out_idx}, 64'd1);
      chk($sformatf("bp in_ready c%0d", k), {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    beat(2, ones, b1, 1'b0);
    beat(3, ones, b1, 1'b0);

    // Abort mid-transaction, then a fresh transaction.
    beat(0, ones, b1, 1'b0);
    beat(1, ones, b1, 1'b0);
    abort = 1'b1; in_valid = 1'b1; in_a = ones[128 +: 64]; in_b = 64'd0;
    #1;
    chk("abort in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    chk("abort busy", {63'd0, busy}, 64'd0);
    chk("abort out_valid", {63'd0, out_valid}, 64'd0);
    abort = 1'b0;
    txn(256'd5, 256'd7, 1'b0);

    // Streaming: three random back-to-back transactions, one beat per cycle.
    for (int t = 0; t < 3; t++) begin
      for (int w = 0; w < 8; w++) begin
        ra[32*w +: 32] = $urandom;
        rb[32*w +: 32] = $urandom;
      end
      if (t == 1) ra = ones;
      txn(ra, rb, 1'($urandom));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle out_valid", {63'd0, out_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mp_add_seq.md
# mp_add_seq

Word-serial multi-precision adder sequencer. It time-shares one 64-bit add-one carry-select adder (`a1csah64`, instantiated inside) to add two `WORDS`×64-bit operands, one 64-bit word per beat, least-significant word first. The carry is chained between beats from the adder's `gen`/`prop` outputs. It sits between an operand streaming source and a result sink, with valid/ready handshakes on both sides.

## Interface

**Parameters**
- `WORDS`, default 4: beats per transaction. Legal range 2..16.
- `CW`, default 4: beat counter width. Must satisfy `CW >= clog2(WORDS)`.

**Ports** (clock and reset first)
- `clk`  input  1: sole clock, rising edge.
- `rst_n`  input  1: reset, synchronous, active-low.
- `abort`  input  1: synchronous cancel of the in-progress transaction.
- `in_valid`  input  1: operand beat valid.
- `in_ready`  output  1: beat accepted when `in_valid & in_ready`.
- `in_a`  input  64: operand A word.
- `in_b`  input  64: operand B word.
- `in_cin`  input  1: transaction carry-in. Sampled only on beat 0.
- `out_valid`  output  1: result beat valid.
- `out_ready`  input  1: sink accepts when `out_valid & out_ready`.
- `out_s`  output  64: sum word.
- `out_idx`  output  CW: beat index of `out_s`.
- `out_last`  output  1: `out_s` is word `WORDS-1`.
- `out_cout`  output  1: transaction carry-out. Meaningful only when `out_last=1`, otherwise 0.
- `busy`  output  1: a transaction is partially accepted (`idx != 0`).

## Operation

**State**
- Beat counter `idx` (0..`WORDS-1`).
- Carry register `cy`.
- One-entry output register: `out_valid`, `out_s`, `out_idx`, `out_last`, `out_cout`.

**Adder hookup**
- The adder's `cin` input is `(idx==0) ? in_cin : cy`.
- `a`/`b` are driven from `in_a`/`in_b`.
- `c_next = gen | (prop & adder_cin)`.

**Handshake**
- `in_ready = ~abort & (~out_valid | out_ready)`.
- Accept is `in_valid & in_ready`.

**On accept**
- The output register loads `s`, `idx`, `(idx==WORDS-1)`, and `(idx==WORDS-1) ? c_next : 0`.
- `out_valid` is set to 1.
- `cy` takes `c_next`.
- `idx` increments, wrapping from `WORDS-1` to 0. On wrap `cy` is cleared, so no carry leaks between transactions.

**Otherwise**
- If `out_valid & out_ready`, `out_valid` clears.
- `out_s`, `out_idx`, `out_last` and `out_cout` hold until the next load.

**abort**
- `idx` and `cy` go to 0, and no beat is accepted that cycle.
- A beat already held in the output register is kept and drains normally. The sink discards any partial transaction (no `out_last` was issued).

**Reset**
- `rst_n=0` on a clock edge forces `idx=0`, `cy=0`, `out_valid=0`, `out_s=0`, `out_idx=0`, `out_last=0`, `out_cout=0`.
- Consequently `busy=0`, and `in_ready=1` once `rst_n` and `abort` are deasserted.
- Reset overrides `abort` and any accept in the same cycle.

**Arithmetic**
- Modulo 2^(64·WORDS), unsigned.
- The result equals A + B + `in_cin`, with `out_cout` as bit 64·WORDS.

## Timing
- Latency: 1 cycle. A beat accepted at edge k is presented at `out_*` after edge k.
- Throughput: 1 beat/cycle while `out_ready=1`. A transaction takes exactly `WORDS` accepted beats. Back-to-back transactions have no bubble.
- Simultaneous drain and accept (`out_valid & out_ready & in_valid`, `abort=0`): the register is overwritten with the new beat and `out_valid` stays 1.
- Backpressure: while `out_valid & ~out_ready`, `in_ready=0` and all `out_*` stay stable.
- The adder is the only combinational path from `in_*`/`idx`/`cy` into registers. `in_ready` depends combinationally on `out_ready` and `abort`; no other input-to-output combinational path exists.

## Test plan
1. **Reset.** Hold `rst_n=0` for 2 cycles with `in_valid=1` → every `out_*`=0, `busy=0`, no beat accepted. After release, `in_ready=1`.
2. **Full ripple.** `WORDS=4`, `in_cin=0`, A = all `0xFFFF_FFFF_FFFF_FFFF`, B words = {1, 0, 0, 0} → four beats of `out_s=0`, `out_idx` 0..3, `out_last` only on idx 3 with `out_cout=1`.
3. **Carry-in only.** A=0, B=0, `in_cin=1` → `out_s` = {1, 0, 0, 0}, `out_cout=0`. In the next transaction, `in_cin=0` and zero operands give all-zero beats, proving `cy` was cleared on wrap.
4. **Backpressure.** `out_ready=0` after beat 1 for 3 cycles → `in_ready=0`, `out_s`/`out_idx=1` stable. After release, beats 2..3 complete with the correct carry chain.
5. **Abort.** Abort after beat 1 of A = all-ones, B = {1, 0, 0, 0}, then start a new transaction with A={5,0,0,0}, B={7,0,0,0}, `in_cin=0` → `busy=0` after abort, new result {12, 0, 0, 0}, `out_cout=0`.
6. **Streaming.** 3 back-to-back random transactions with `out_ready=1` → 12 beats in 12 cycles, `idx` wraps 3→0 with no bubble, and every result matches a 257-bit reference sum.
